// File: rtl/des_round_ctrl.sv
// DES round controller: sequences 16 Feistel rounds and produces the per-round {C,D}
// key state for a PC-2 datapath, with abort/flush and output back-pressure.
module des_round_ctrl #(
    parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [55:0] key_cd_in,
    input  logic        abort,
    output logic        load_msg,
    output logic        rnd_en,
    output logic [4:0]  rnd_idx,
    output logic [55:0] round_cd,
    output logic        final_swap,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state_r;
    logic [55:0] cd_r;
    logic [4:0]  rnd_idx_r;
    logic        mode_r;

    logic        accept_s;
    logic        last_round_s;
    logic        idx_legal_s;
    logic        enc_one_s;
    logic        dec_one_s;
    logic        load_one_s;
    logic [55:0] cd_load_s;
    logic [55:0] cd_next_s;

    // Rotate amount for round k (1..16): returns 1 for a single-bit rotate, 0 for two bits.
    function automatic logic amt_is_one(input logic [4:0] k);
        logic [4:0] idx;
        idx = k - 5'd1;
        return SHIFT_MASK[idx[3:0]];
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic one);
        return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    // Output decodes of registered state; only load_msg looks at the live handshake.
    always_comb begin
        in_ready   = (state_r == ST_IDLE);
        accept_s   = in_valid && (state_r == ST_IDLE) && !abort && !rst;
        load_msg   = accept_s;
        rnd_en     = (state_r == ST_ROUND);
        final_swap = (state_r == ST_ROUND) && (rnd_idx_r == 5'd16);
        out_valid  = (state_r == ST_DONE);
        busy       = (state_r != ST_IDLE);
        rnd_idx    = rnd_idx_r;
        round_cd   = cd_r;
    end

    // Key-schedule arithmetic: initial load and per-round advance, halves rotated independently.
    always_comb begin
        last_round_s = (rnd_idx_r == 5'd16);
        idx_legal_s  = (rnd_idx_r != 5'd0) && (rnd_idx_r <= 5'd16);
        load_one_s   = amt_is_one(5'd1);
        enc_one_s    = amt_is_one(rnd_idx_r + 5'd1);
        dec_one_s    = amt_is_one(5'd17 - rnd_idx_r);
        if (mode) begin
            cd_load_s = key_cd_in;
        end else begin
            cd_load_s = {rotl28(key_cd_in[55:28], load_one_s), rotl28(key_cd_in[27:0], load_one_s)};
        end
        if (mode_r) begin
            cd_next_s = {rotr28(cd_r[55:28], dec_one_s), rotr28(cd_r[27:0], dec_one_s)};
        end else begin
            cd_next_s = {rotl28(cd_r[55:28], enc_one_s), rotl28(cd_r[27:0], enc_one_s)};
        end
    end

    // Controller state: reset, then abort, then the normal IDLE/ROUND/DONE flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cd_r      <= 56'd0;
            rnd_idx_r <= 5'd0;
            mode_r    <= 1'b0;
        end else if (abort) begin
            state_r   <= ST_IDLE;
            rnd_idx_r <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mode_r    <= mode;
                        cd_r      <= cd_load_s;
                        rnd_idx_r <= 5'd1;
                        state_r   <= ST_ROUND;
                    end else begin
                        rnd_idx_r <= 5'd0;
                    end
                end
                ST_ROUND: begin
                    if (!idx_legal_s) begin
                        // corrupted round counter: drop the block rather than emit garbage
                        state_r   <= ST_IDLE;
                        rnd_idx_r <= 5'd0;
                    end else if (last_round_s) begin
                        state_r   <= ST_DONE;
                        rnd_idx_r <= 5'd0;
                    end else begin
                        cd_r      <= cd_next_s;
                        rnd_idx_r <= rnd_idx_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    rnd_idx_r <= 5'd0;
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rnd_idx_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: expected {C,D} values come from the standard DES
// shift schedule applied by cumulative single-bit rotation, plus hand-derived constants.
module tb_des_round_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, mode, abort, out_ready;
    logic [55:0] key_cd_in;
    logic        in_ready, load_msg, rnd_en, final_swap, out_valid, busy;
    logic [4:0]  rnd_idx;
    logic [55:0] round_cd;

    int vectors = 0;
    int miscompares = 0;
    logic [55:0] cd_at [1:16];

    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
    localparam logic [55:0] KEY_B = 56'h123456789ABCDE;

    des_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .key_cd_in(key_cd_in), .abort(abort), .load_msg(load_msg), .rnd_en(rnd_en),
        .rnd_idx(rnd_idx), .round_cd(round_cd), .final_swap(final_swap),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // Round r cd from the standard DES schedule (rounds 1,2,9,16 shift by one).
    function automatic logic [55:0] exp_cd(input logic m, input logic [55:0] key, input int r);
        int rr;
        int total;
        logic [27:0] c;
        logic [27:0] d;
        rr = m ? (17 - r) : r;
        total = 0;
        for (int k = 1; k <= rr; k++) begin
            if (k == 1 || k == 2 || k == 9 || k == 16) total += 1;
            else total += 2;
        end
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < total; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic m, input logic [55:0] key);
        mode = m; key_cd_in = key; in_valid = 1'b1; abort = 1'b0;
        #1;
        vectors++;
        if ({in_ready, load_msg, busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL accept_strobe: {in_ready,load_msg,busy} got %b expected 110", {in_ready, load_msg, busy});
        end
    endtask

    task automatic finish_block(input logic m, input logic [55:0] key, input bit perturb, input int hold);
        for (int r = 1; r <= 16; r++) begin
            tick;
            if (perturb) begin
                mode = ~mode; key_cd_in = ~key_cd_in; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            vectors++;
            if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy} !== {4'b0010, 1'b0, 1'b1} + {3'b000, (r == 16), 2'b00}) begin
                miscompares++;
                $display("FAIL round_status r=%0d: {in_ready,load_msg,rnd_en,final_swap,out_valid,busy} got %b", r,
                         {in_ready, load_msg, rnd_en, final_swap, out_valid, busy});
            end
            vectors++;
            if (rnd_idx !== r[4:0]) begin
                miscompares++;
                $display("FAIL rnd_idx: got %0d expected %0d", rnd_idx, r);
            end
            vectors++;
            if (round_cd !== exp_cd(m, key, r)) begin
                miscompares++;
                $display("FAIL round_cd r=%0d: got %h expected %h", r, round_cd, exp_cd(m, key, r));
            end
            cd_at[r] = round_cd;
        end
        for (int h = 0; h <= hold; h++) begin
            tick;
            in_valid = 1'b0;
            #1;
            vectors++;
            if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy, rnd_idx} !== {6'b000011, 5'd0}) begin
                miscompares++;
                $display("FAIL done_hold h=%0d: status got %b idx %0d expected 000011 idx 0", h,
                         {in_ready, load_msg, rnd_en, final_swap, out_valid, busy}, rnd_idx);
            end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy} !== 6'b100000) begin
            miscompares++;
            $display("FAIL out_handshake: status got %b expected 100000",
                     {in_ready, load_msg, rnd_en, final_swap, out_valid, busy});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; mode = 1'b0; key_cd_in = KEY_A; abort = 1'b1; out_ready = 1'b1;
        tick;
        tick;
        vectors++;
        if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy, rnd_idx, round_cd} !== {6'b100000, 5'd0, 56'd0}) begin
            miscompares++;
            $display("FAIL reset_hold: status %b idx %0d cd %h expected 100000 0 0",
                     {in_ready, load_msg, rnd_en, final_swap, out_valid, busy}, rnd_idx, round_cd);
        end
        rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        tick;
        vectors++;
        if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy, rnd_idx} !== {6'b100000, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_release: status %b idx %0d expected 100000 0",
                     {in_ready, load_msg, rnd_en, final_swap, out_valid, busy}, rnd_idx);
        end
    endtask

    task automatic test_encrypt;
        accept(1'b0, KEY_A);
        finish_block(1'b0, KEY_A, 1'b0, 0);
        vectors++;
        if (cd_at[1] !== 56'hE19955FAACCF1E) begin
            miscompares++;
            $display("FAIL enc_round1: got %h expected E19955FAACCF1E", cd_at[1]);
        end
        vectors++;
        if (cd_at[16] !== KEY_A) begin
            miscompares++;
            $display("FAIL enc_round16: got %h expected %h", cd_at[16], KEY_A);
        end
    endtask

    task automatic test_decrypt;
        accept(1'b1, KEY_A);
        finish_block(1'b1, KEY_A, 1'b0, 0);
        vectors++;
        if ({cd_at[1], cd_at[2], cd_at[16]} !== {KEY_A, 56'hF866557AAB33C7, 56'hE19955FAACCF1E}) begin
            miscompares++;
            $display("FAIL dec_rounds: got %h %h %h expected %h F866557AAB33C7 E19955FAACCF1E",
                     cd_at[1], cd_at[2], cd_at[16], KEY_A);
        end
    endtask

    task automatic test_backpressure;
        accept(1'b0, KEY_B);
        finish_block(1'b0, KEY_B, 1'b0, 5);
    endtask

    task automatic test_perturb;
        accept(1'b1, KEY_B);
        finish_block(1'b1, KEY_B, 1'b1, 0);
    endtask

    task automatic test_abort;
        logic [55:0] cd7;
        accept(1'b0, KEY_A);
        for (int r = 1; r <= 7; r++) begin
            tick;
            in_valid = 1'b0;
        end
        cd7 = exp_cd(1'b0, KEY_A, 7);
        abort = 1'b1;
        tick;
        vectors++;
        if ({in_ready, rnd_en, final_swap, out_valid, busy, rnd_idx, round_cd} !== {5'b10000, 5'd0, cd7}) begin
            miscompares++;
            $display("FAIL abort_flush: status %b idx %0d cd %h expected 10000 0 %h",
                     {in_ready, rnd_en, final_swap, out_valid, busy}, rnd_idx, round_cd, cd7);
        end
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            vectors++;
            if ({out_valid, final_swap, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_quiet: {out_valid,final_swap,busy} got %b expected 000", {out_valid, final_swap, busy});
            end
        end
        accept(1'b0, KEY_B);
        finish_block(1'b0, KEY_B, 1'b0, 0);
    endtask

    task automatic test_rst_mid;
        accept(1'b1, KEY_A);
        for (int r = 1; r <= 10; r++) begin
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mode = 1'b0; key_cd_in = KEY_B;
        #1;
        vectors++;
        if ({in_ready, load_msg, rnd_en, final_swap, out_valid, busy, rnd_idx, round_cd} !== {6'b110000, 5'd0, 56'd0}) begin
            miscompares++;
            $display("FAIL rst_mid: status %b idx %0d cd %h expected 110000 0 0",
                     {in_ready, load_msg, rnd_en, final_swap, out_valid, busy}, rnd_idx, round_cd);
        end
        finish_block(1'b0, KEY_B, 1'b0, 0);
    endtask

    task automatic test_abort_idle;
        in_valid = 1'b1; abort = 1'b1; mode = 1'b0; key_cd_in = KEY_A;
        #1;
        vectors++;
        if ({in_ready, load_msg} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_idle_strobe: {in_ready,load_msg} got %b expected 10", {in_ready, load_msg});
        end
        tick;
        in_valid = 1'b0; abort = 1'b0;
        vectors++;
        if ({busy, rnd_en, rnd_idx} !== {2'b00, 5'd0}) begin
            miscompares++;
            $display("FAIL abort_idle_state: busy %b rnd_en %b idx %0d expected 0 0 0", busy, rnd_en, rnd_idx);
        end
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_perturb;
        test_abort;
        test_rst_mid;
        test_abort_idle;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
